// File: rtl/riscv_mc_pkg.sv
// Shared encodings for the multicycle RISC-V control path: FSM states,
// opcodes, ALU operation classes and alu_control codes.
package riscv_mc_pkg;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_ALUWB    = 4'd7;
  localparam logic [3:0] S_EXECUTEI = 4'd8;
  localparam logic [3:0] S_JAL      = 4'd9;
  localparam logic [3:0] S_BRANCH   = 4'd10;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_e;

  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_STORE:  return 2'b01;
      OP_BRANCH: return 2'b10;
      OP_JAL:    return 2'b11;
      default:   return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// Combinational ALU control decode from the FSM's operation class and
// the instruction's funct fields.
module mc_alu_decoder
  import riscv_mc_pkg::*;
(
  input  alu_op_e    alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       is_rtype,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_control = (is_rtype && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b100:  alu_control = ALU_XOR;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle RISC-V main control FSM (Moore). Define MC_WAIT_EN to make
// FETCH/MEMREAD/MEMWRITE stall until mem_ready.
module mc_control_fsm
  import riscv_mc_pkg::*;
#(
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         opcode,
  input  logic [2:0]         funct3,
  input  logic               funct7b5,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               adr_src,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_write,
  output logic [1:0]         result_src,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         imm_src,
  output logic [2:0]         alu_control,
  output logic               illegal,
  output logic [STATE_W-1:0] state
);

  localparam logic [STATE_W-1:0] ST_FETCH    = STATE_W'(S_FETCH);
  localparam logic [STATE_W-1:0] ST_DECODE   = STATE_W'(S_DECODE);
  localparam logic [STATE_W-1:0] ST_MEMADR   = STATE_W'(S_MEMADR);
  localparam logic [STATE_W-1:0] ST_MEMREAD  = STATE_W'(S_MEMREAD);
  localparam logic [STATE_W-1:0] ST_MEMWB    = STATE_W'(S_MEMWB);
  localparam logic [STATE_W-1:0] ST_MEMWRITE = STATE_W'(S_MEMWRITE);
  localparam logic [STATE_W-1:0] ST_EXECUTER = STATE_W'(S_EXECUTER);
  localparam logic [STATE_W-1:0] ST_ALUWB    = STATE_W'(S_ALUWB);
  localparam logic [STATE_W-1:0] ST_EXECUTEI = STATE_W'(S_EXECUTEI);
  localparam logic [STATE_W-1:0] ST_JAL      = STATE_W'(S_JAL);
  localparam logic [STATE_W-1:0] ST_BRANCH   = STATE_W'(S_BRANCH);

  logic [STATE_W-1:0] state_q, state_d;
  logic               mem_done;
  alu_op_e            alu_op;
  logic               is_rtype;
  logic [2:0]         dec_alu;
  logic               take_branch;

`ifdef MC_WAIT_EN
  assign mem_done = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_done         = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:    if (mem_done) state_d = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = ST_MEMADR;
          OP_RTYPE:          state_d = ST_EXECUTER;
          OP_ITYPE:          state_d = ST_EXECUTEI;
          OP_JAL:            state_d = ST_JAL;
          OP_BRANCH:         state_d = ST_BRANCH;
          default:           state_d = ST_FETCH;
        endcase
      end
      ST_MEMADR:   state_d = opcode[5] ? ST_MEMWRITE : ST_MEMREAD;
      ST_MEMREAD:  if (mem_done) state_d = ST_MEMWB;
      ST_MEMWB:    state_d = ST_FETCH;
      ST_MEMWRITE: if (mem_done) state_d = ST_FETCH;
      ST_EXECUTER, ST_EXECUTEI, ST_JAL: state_d = ST_ALUWB;
      ST_ALUWB:    state_d = ST_FETCH;
      ST_BRANCH:   state_d = ST_FETCH;
      default:     state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_FETCH;
    else       state_q <= state_d;
  end

  assign is_rtype    = (state_q == ST_EXECUTER);
  assign take_branch = ((funct3 == 3'b000) && zero) || ((funct3 == 3'b001) && !zero);

  mc_alu_decoder u_alu_dec (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .is_rtype    (is_rtype),
    .alu_control (dec_alu)
  );

  // Reset forces every control output low combinationally, not just the state.
  always_comb begin
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = ALUOP_ADD;
    illegal    = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_FETCH: begin
          ir_write   = mem_done;
          pc_write   = mem_done;
          alu_src_b  = 2'b10;
          result_src = 2'b10;
        end
        ST_DECODE: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b01;
          case (opcode)
            OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_JAL, OP_BRANCH: illegal = 1'b0;
            default: illegal = 1'b1;
          endcase
        end
        ST_MEMADR: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
        end
        ST_MEMREAD: adr_src = 1'b1;
        ST_MEMWB: begin
          result_src = 2'b01;
          reg_write  = 1'b1;
        end
        ST_MEMWRITE: begin
          adr_src   = 1'b1;
          mem_write = mem_done;
        end
        ST_EXECUTER: begin
          alu_src_a = 2'b10;
          alu_op    = ALUOP_FUNCT;
        end
        ST_EXECUTEI: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
          alu_op    = ALUOP_FUNCT;
        end
        ST_ALUWB: reg_write = 1'b1;
        ST_JAL: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b10;
          pc_write  = 1'b1;
        end
        ST_BRANCH: begin
          alu_src_a = 2'b10;
          alu_op    = ALUOP_SUB;
          pc_write  = take_branch;
        end
        default: ;
      endcase
    end
  end

  assign alu_control = reset ? 3'b000 : dec_alu;
  assign imm_src     = imm_src_of(opcode);
  assign state       = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: a per-instruction state-path model plus
// per-state output table, checked every cycle, with literal pins per case.
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5, zero, mem_ready;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  logic [3:0] state;

  typedef struct packed {
    logic [3:0] st;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu;
    logic       illegal;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;
  int   regw_cnt, memw_cnt, ill_cnt;
  logic [2:0] exec_alu;
  logic       br_pcw;

`ifdef MC_WAIT_EN
  localparam bit WAIT_BUILD = 1'b1;
`else
  localparam bit WAIT_BUILD = 1'b0;
`endif

  always #5 clk = ~clk;

  mc_control_fsm #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3),
    .funct7b5(funct7b5), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
    .ir_write(ir_write), .reg_write(reg_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
    .alu_control(alu_control), .illegal(illegal), .state(state)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected state sequence for one instruction, starting at FETCH.
  function automatic void path_of(input logic [6:0] op, output int p[$]);
    p = {0, 1};
    case (op)
      7'b0000011: p = {0, 1, 2, 3, 4};
      7'b0100011: p = {0, 1, 2, 5};
      7'b0110011: p = {0, 1, 6, 7};
      7'b0010011: p = {0, 1, 8, 7};
      7'b1101111: p = {0, 1, 9, 7};
      7'b1100011: p = {0, 1, 10};
      default:    p = {0, 1};
    endcase
  endfunction

  function automatic logic [2:0] alu_of(input logic [2:0] f3, input logic f7, input bit rtype);
    case (f3)
      3'd0: return (rtype && f7) ? 3'd1 : 3'd0;
      3'd2: return 3'd5;
      3'd4: return 3'd4;
      3'd6: return 3'd3;
      3'd7: return 3'd2;
      default: return 3'd0;
    endcase
  endfunction

  // Output table keyed by state number, from the per-state rules.
  function automatic exp_t mdl(input int s, input logic rdy, input logic rst);
    exp_t e;
    logic g;
    bit   legal;
    e = '0;
    e.st = 4'(s);
    case (opcode)
      7'b0100011: e.imm_src = 2'b01;
      7'b1100011: e.imm_src = 2'b10;
      7'b1101111: e.imm_src = 2'b11;
      default:    e.imm_src = 2'b00;
    endcase
    if (rst) return e;
    g = WAIT_BUILD ? rdy : 1'b1;
    legal = opcode inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111, 7'b1100011};
    case (s)
      0:  begin e.ir_write = g; e.pc_write = g; e.alu_src_b = 2; e.result_src = 2; end
      1:  begin e.alu_src_a = 1; e.alu_src_b = 1; e.illegal = !legal; end
      2:  begin e.alu_src_a = 2; e.alu_src_b = 1; end
      3:  e.adr_src = 1;
      4:  begin e.result_src = 1; e.reg_write = 1; end
      5:  begin e.adr_src = 1; e.mem_write = g; end
      6:  begin e.alu_src_a = 2; e.alu = alu_of(funct3, funct7b5, 1); end
      7:  e.reg_write = 1;
      8:  begin e.alu_src_a = 2; e.alu_src_b = 1; e.alu = alu_of(funct3, funct7b5, 0); end
      9:  begin e.alu_src_a = 1; e.alu_src_b = 2; e.pc_write = 1; end
      10: begin
        e.alu_src_a = 2; e.alu = 3'd1;
        e.pc_write = ((funct3 == 3'd0) && zero) || ((funct3 == 3'd1) && !zero);
      end
      default: ;
    endcase
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input logic z, input int unsigned waits);
    int p[$];
    opcode = op; funct3 = f3; funct7b5 = f7; zero = z;
    regw_cnt = 0; memw_cnt = 0; ill_cnt = 0; exec_alu = 3'bx; br_pcw = 1'bx;
    path_of(op, p);
    foreach (p[i]) begin
      if (p[i] inside {0, 3, 5}) begin
        if (WAIT_BUILD) begin
          for (int unsigned w = 0; w < waits; w++) begin
            mem_ready = 1'b0;
            expq.push_back(mdl(p[i], 1'b0, 1'b0));
            step();
          end
          mem_ready = 1'b1;
        end else begin
          mem_ready = (waits == 0);
        end
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      expq.push_back(mdl(p[i], mem_ready, 1'b0));
      step();
    end
  endtask

  // Per-cycle comparison against the model queue, plus probes for literal pins.
  initial begin
    exp_t e, a;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        a = {state, pc_write, adr_src, mem_write, ir_write, reg_write,
             result_src, alu_src_a, alu_src_b, imm_src, alu_control, illegal};
        chk("state", 32'(a.st), 32'(e.st));
        chk("outputs", 32'(a[16:0]), 32'(e[16:0]));
        regw_cnt += int'(reg_write);
        memw_cnt += int'(mem_write);
        ill_cnt  += int'(illegal);
        if (state == 4'd6 || state == 4'd8) exec_alu = alu_control;
        if (state == 4'd10) br_pcw = pc_write;
      end
    end
  end

  initial begin
    int p[$];
    reset = 1'b1; opcode = 7'b0000011; funct3 = 3'd0; funct7b5 = 1'b0;
    zero = 1'b0; mem_ready = 1'b0;
    step();
    for (int i = 0; i < 2; i++) begin
      expq.push_back(mdl(0, 1'b0, 1'b1));
      step();
    end
    reset = 1'b0;

    // lw: five states, single write-back from MEMWB
    run_instr(7'b0000011, 3'd2, 1'b0, 1'b0, 0);
    chk("lw_regw_count", 32'(regw_cnt), 32'd1);
    run_instr(7'b0100011, 3'd2, 1'b0, 1'b0, 2);
    chk("sw_memw_count", 32'(memw_cnt), 32'd1);
    chk("sw_regw_count", 32'(regw_cnt), 32'd0);

    run_instr(7'b0110011, 3'd0, 1'b1, 1'b0, 0);
    chk("sub_alu", 32'(exec_alu), 32'h1);
    run_instr(7'b0010011, 3'd0, 1'b1, 1'b0, 0);
    chk("addi_f7_alu", 32'(exec_alu), 32'h0);
    run_instr(7'b0110011, 3'd7, 1'b0, 1'b0, 0);
    chk("and_alu", 32'(exec_alu), 32'h2);
    run_instr(7'b0110011, 3'd6, 1'b0, 1'b0, 0);
    chk("or_alu", 32'(exec_alu), 32'h3);
    run_instr(7'b0010011, 3'd4, 1'b0, 1'b0, 0);
    chk("xori_alu", 32'(exec_alu), 32'h4);
    run_instr(7'b0010011, 3'd2, 1'b0, 1'b0, 0);
    chk("slti_alu", 32'(exec_alu), 32'h5);
    run_instr(7'b0110011, 3'd1, 1'b0, 1'b0, 0);
    chk("f3_001_alu", 32'(exec_alu), 32'h0);

    run_instr(7'b1100011, 3'd0, 1'b0, 1'b1, 0);
    chk("beq_taken", 32'(br_pcw), 32'h1);
    run_instr(7'b1100011, 3'd0, 1'b0, 1'b0, 0);
    chk("beq_not_taken", 32'(br_pcw), 32'h0);
    run_instr(7'b1100011, 3'd1, 1'b0, 1'b1, 0);
    chk("bne_not_taken", 32'(br_pcw), 32'h0);
    run_instr(7'b1100011, 3'd1, 1'b0, 1'b0, 0);
    chk("bne_taken", 32'(br_pcw), 32'h1);
    run_instr(7'b1100011, 3'd4, 1'b0, 1'b1, 0);
    chk("blt_no_branch", 32'(br_pcw), 32'h0);

    run_instr(7'b1101111, 3'd0, 1'b0, 1'b0, 0);
    chk("jal_regw_count", 32'(regw_cnt), 32'd1);

    run_instr(7'b0000000, 3'd0, 1'b0, 1'b0, 0);
    chk("illegal_pulses", 32'(ill_cnt), 32'd1);
    chk("illegal_regw", 32'(regw_cnt), 32'd0);
    chk("illegal_memw", 32'(memw_cnt), 32'd0);

    run_instr(7'b0000011, 3'd2, 1'b0, 1'b0, 3);
    chk("lw_wait_regw", 32'(regw_cnt), 32'd1);
    run_instr(7'b0100011, 3'd2, 1'b0, 1'b0, 3);
    chk("sw_wait_memw", 32'(memw_cnt), 32'd1);

    // reset raised while in MEMREAD, held one extra cycle, then released
    opcode = 7'b0000011; funct3 = 3'd2; mem_ready = 1'b1;
    path_of(opcode, p);
    for (int i = 0; i < 3; i++) begin
      expq.push_back(mdl(p[i], 1'b1, 1'b0));
      step();
    end
    reset = 1'b1;
    expq.push_back(mdl(3, 1'b1, 1'b1));
    step();
    expq.push_back(mdl(0, 1'b1, 1'b1));
    step();
    reset = 1'b0;
    run_instr(7'b0010011, 3'd0, 1'b0, 1'b0, 0);
    chk("post_reset_alu", 32'(exec_alu), 32'h0);

    @(negedge clk);
    #1;
    chk("queue_drained", 32'(expq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 SHALL have parameter STATE_W, default 4, width of the state register and debug port.
REQ-002 SHALL have port clk, input, 1: single system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1: reset is synchronous and active-high.
REQ-004 SHALL have port opcode, input, 7: instr[6:0] from the instruction register.
REQ-005 SHALL have port funct3, input, 3: instr[14:12].
REQ-006 SHALL have port funct7b5, input, 1: instr[30].
REQ-007 SHALL have port zero, input, 1: ALU zero flag.
REQ-008 SHALL have port mem_ready, input, 1: memory/peripheral access done; used only when MC_WAIT_EN is defined.
REQ-009 SHALL have outputs pc_write, adr_src, mem_write, ir_write, reg_write, each 1 bit.
REQ-010 SHALL have outputs result_src, alu_src_a, alu_src_b and imm_src, each 2 bits.
REQ-011 SHALL have output alu_control, 3 bits.
REQ-012 SHALL have output illegal, 1 bit: one-cycle pulse on an unsupported opcode.
REQ-013 SHALL have output state, STATE_W bits: current state, debug only.

Function
REQ-014 SHALL implement Moore FSM states FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, ALUWB=7, EXECUTEI=8, JAL=9, BRANCH=10.
REQ-015 Transitions SHALL be: FETCH->DECODE.
REQ-016 From DECODE, opcode 0000011/0100011->MEMADR, 0110011->EXECUTER, 0010011->EXECUTEI, 1101111->JAL, 1100011->BRANCH, any other->FETCH with illegal=1 for that cycle.
REQ-017 SHALL go MEMADR->MEMREAD if opcode[5]=0, else MEMWRITE.
REQ-018 SHALL go MEMREAD->MEMWB->FETCH; MEMWRITE->FETCH; EXECUTER/EXECUTEI/JAL->ALUWB->FETCH; BRANCH->FETCH.
REQ-019 SHALL drive unlisted outputs to 0 in every state (the per-state values below list only the non-zero outputs).
REQ-020 FETCH: ir_write=1, alu_src_b=10, result_src=10, pc_write=1, ALU add.
REQ-021 DECODE: alu_src_a=01, alu_src_b=01, ALU add.
REQ-022 MEMADR: alu_src_a=10, alu_src_b=01, ALU add.
REQ-023 MEMREAD: adr_src=1. MEMWB: result_src=01, reg_write=1. MEMWRITE: adr_src=1, mem_write=1.
REQ-024 EXECUTER: alu_src_a=10, ALU decoded. EXECUTEI: alu_src_a=10, alu_src_b=01, ALU decoded. ALUWB: reg_write=1.
REQ-025 JAL: alu_src_a=01, alu_src_b=10, pc_write=1, ALU add.
REQ-026 BRANCH: alu_src_a=10, ALU sub; pc_write=1 iff (funct3=000 and zero=1) or (funct3=001 and zero=0); other funct3 values SHALL not branch.
REQ-027 alu_control SHALL be add=000, sub=001, and=010, or=011, xor=100, slt=101.
REQ-028 Decoded ALU: funct3 000->sub if EXECUTER and funct7b5=1, else add; 010->slt; 100->xor; 110->or; 111->and; other funct3->add.
REQ-029 imm_src SHALL decode combinationally from opcode: 0100011->01, 1100011->10, 1101111->11, all others->00.

Reset
REQ-030 On reset=1 at a clock edge, state SHALL become FETCH, overriding any transition, including mid-instruction and mid-wait.
REQ-031 While reset=1, all outputs except imm_src and state SHALL be 0; on the first edge after release, FETCH outputs of REQ-020 apply.

Configuration
REQ-032 With MC_WAIT_EN defined, FETCH, MEMREAD and MEMWRITE SHALL hold their state until mem_ready=1.
REQ-033 With MC_WAIT_EN defined, ir_write and pc_write in FETCH and mem_write in MEMWRITE SHALL assert only in the cycle mem_ready=1.
REQ-034 Without MC_WAIT_EN, mem_ready SHALL be ignored and every state SHALL last exactly one cycle.

Structure
REQ-035 Package riscv_mc_pkg SHALL hold the state encodings, opcode constants and alu_control codes.
REQ-036 The combinational ALU decode SHALL be sub-module mc_alu_decoder (inputs alu_op[1:0], funct3, funct7b5, is_rtype; output alu_control).

Verification
REQ-037 lw (opcode 0000011), no macro -> states 0,1,2,3,4,0 over 5 cycles; reg_write=1 only in MEMWB with result_src=01.
REQ-038 add/sub: opcode 0110011, funct3 000, funct7b5=1 -> alu_control=001 in EXECUTER; same with opcode 0010011 -> alu_control=000.
REQ-039 beq with zero=1 -> pc_write=1 in BRANCH; bne (funct3 001) with zero=1 -> pc_write=0; funct3 100 -> pc_write=0.
REQ-040 opcode 0000000 -> illegal=1 in DECODE cycle, next state FETCH, reg_write and mem_write stay 0.
REQ-041 MC_WAIT_EN, sw with mem_ready low for 3 cycles in MEMWRITE -> state held at 5, mem_write=0 until mem_ready=1, then one mem_write pulse and FETCH.
REQ-042 reset asserted during MEMREAD -> state=0 next edge, all outputs 0 while held.
